// File: rtl/pio_display_arbiter_if.sv
// rtl/pio_display_arbiter_if.sv - host/local request and display/status bundle for the display arbiter
interface pio_display_arbiter_if;
  logic [31:0] host_data;
  logic [31:0] local_data;
  logic        local_req;
  logic [55:0] hex_seg;
  logic        owner;
  logic [15:0] status;

  modport master (
    output host_data,
    output local_data,
    output local_req,
    input  hex_seg,
    input  owner,
    input  status
  );

  modport slave (
    input  host_data,
    input  local_data,
    input  local_req,
    output hex_seg,
    output owner,
    output status
  );
endinterface

// File: rtl/pio_display_arbiter.sv
// rtl/pio_display_arbiter.sv - dwell-time, round-robin arbiter sharing the 8-digit display between host and local
module pio_display_arbiter #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  pio_display_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  // Reset glyph: '0' on every digit in the configured polarity
  localparam logic [55:0] RESET_HEX = ACTIVE_LOW ? {8{7'h40}} : {8{7'h3F}};

  // Active-high {g,f,e,d,c,b,a} glyph for one hex nibble
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [31:0]      disp_q, disp_d;
  logic [31:0]      host_shadow_q, host_shadow_d;
  logic [31:0]      l_buf_q, l_buf_d;
  logic             l_pend_q, l_pend_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       grant_cnt_q, grant_cnt_d;
  logic [55:0]      hex_seg_q, hex_seg_d;
  logic [15:0]      status_q, status_d;

  logic             h_pend;
  logic             grant_host;
  logic             grant_local;

  // A host request is simply a host word that differs from what was last shown for the host;
  // reverting the word before it is granted therefore withdraws the request.
  assign h_pend = (bus.host_data != host_shadow_q);

  // Grant selection in IDLE: a lone requester wins; on contention the side that did not
  // win last time goes first (last_grant holds the owner of the previous grant).
  always_comb begin
    grant_host  = 1'b0;
    grant_local = 1'b0;
    if (state_q == ST_IDLE) begin
      if (h_pend && (!l_pend_q || last_grant_q)) begin
        grant_host = 1'b1;
      end else if (l_pend_q) begin
        grant_local = 1'b1;
      end
    end
  end

  // Next-state for display, shadows, pending flags, dwell FSM and grant counter
  always_comb begin
    disp_d        = disp_q;
    host_shadow_d = host_shadow_q;
    l_buf_d       = l_buf_q;
    l_pend_d      = l_pend_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_cnt_d   = grant_cnt_q;

    if (grant_host) begin
      disp_d        = bus.host_data;
      host_shadow_d = bus.host_data;
      owner_d       = 1'b0;
      last_grant_d  = 1'b0;
    end else if (grant_local) begin
      // The grant shows the buffered value from before this cycle, even if a new pulse lands now
      disp_d        = l_buf_q;
      l_pend_d      = 1'b0;
      owner_d       = 1'b1;
      last_grant_d  = 1'b1;
    end

    if (grant_host || grant_local) begin
      grant_cnt_d = grant_cnt_q + 8'd1;
      cnt_d       = DWELL_LOAD;
      state_d     = ST_HOLD;
    end else if (state_q == ST_HOLD) begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // A new local pulse always re-arms the request; the latest pulse's data wins
    if (bus.local_req) begin
      l_buf_d  = bus.local_data;
      l_pend_d = 1'b1;
    end
  end

  // Segment decode of the current display word, one glyph per nibble
  always_comb begin
    hex_seg_d = '0;
    for (int i = 0; i < 8; i++) begin
      hex_seg_d[7*i +: 7] = ACTIVE_LOW ? ~seg_glyph(disp_q[4*i +: 4])
                                       :  seg_glyph(disp_q[4*i +: 4]);
    end
  end

  // Status word snapshot of the current cycle, presented one cycle later
  always_comb begin
    status_d = {owner_q, h_pend, l_pend_q, (state_q == ST_HOLD), 4'b0000, grant_cnt_q};
  end

  // State registers; reset overrides everything, including an in-progress hold
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q        <= '0;
      host_shadow_q <= '0;
      l_buf_q       <= '0;
      l_pend_q      <= 1'b0;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      grant_cnt_q   <= '0;
      hex_seg_q     <= RESET_HEX;
      status_q      <= '0;
    end else begin
      disp_q        <= disp_d;
      host_shadow_q <= host_shadow_d;
      l_buf_q       <= l_buf_d;
      l_pend_q      <= l_pend_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_cnt_q   <= grant_cnt_d;
      hex_seg_q     <= hex_seg_d;
      status_q      <= status_d;
    end
  end

  assign bus.hex_seg = hex_seg_q;
  assign bus.owner   = owner_q;
  assign bus.status  = status_q;

endmodule
